// File: rtl/clkdiv_pkg.sv
// ============================================================================
// clkdiv_pkg : shared mode encoding, default counter width, channel-index width
// Revision   : 1.0
// ============================================================================
`default_nettype none

package clkdiv_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } clkdiv_mode_e;

  localparam int CLKDIV_CNT_W = 32;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clkdiv_chan.sv
// ============================================================================
// clkdiv_chan : one divider channel (counter, active/pending config, output)
// Optional macro CLKDIV_SYNC_EN adds the sync realignment input.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int CNT_W       = CLKDIV_CNT_W,
  parameter int DEFAULT_DIV = 1
) (
  input  logic             clkin,
  input  logic             rst,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_div,
  input  clkdiv_mode_e     wr_mode,
  output logic             clkout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  clkdiv_mode_e     mode_q, mode_d;
  clkdiv_mode_e     pend_mode_q, pend_mode_d;
  logic             clkout_q, clkout_d;
  logic             busy_q, busy_d;

  logic halted;
  logic tc;
  logic apply;
  logic tc_level;
  logic sync_hit;

  assign halted   = (div_q == '0);
  assign tc       = !halted && (cnt_q == div_q);
  assign apply    = busy_q && (tc || halted);
  assign tc_level = (mode_q == MODE_TOGGLE) ? ~clkout_q : 1'b1;

`ifdef CLKDIV_SYNC_EN
  assign sync_hit = sync && !halted;
`else
  assign sync_hit = 1'b0;
`endif

  always_comb begin
    cnt_d       = cnt_q;
    div_d       = div_q;
    mode_d      = mode_q;
    clkout_d    = clkout_q;
    busy_d      = busy_q;
    pend_div_d  = pend_div_q;
    pend_mode_d = pend_mode_q;

    if (sync_hit) begin
      cnt_d    = CNT_ONE;
      clkout_d = 1'b0;
      if (busy_q) begin
        div_d  = pend_div_q;
        mode_d = pend_mode_q;
        busy_d = 1'b0;
      end
    end else if (apply) begin
      div_d  = pend_div_q;
      mode_d = pend_mode_q;
      cnt_d  = CNT_ONE;
      busy_d = 1'b0;
      // Only an unchanged mode with a live divisor continues the waveform seamlessly
      clkout_d = (tc && (pend_div_q != '0) && (pend_mode_q == mode_q)) ? tc_level : 1'b0;
    end else if (tc) begin
      cnt_d    = CNT_ONE;
      clkout_d = tc_level;
    end else if (halted) begin
      cnt_d    = CNT_ONE;
      clkout_d = 1'b0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
      if (mode_q == MODE_PULSE) begin
        clkout_d = 1'b0;
      end
    end

    if (wr_en) begin
      pend_div_d  = wr_div;
      pend_mode_d = wr_mode;
      busy_d      = 1'b1;
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      cnt_q       <= CNT_ONE;
      div_q       <= CNT_W'(DEFAULT_DIV);
      mode_q      <= MODE_TOGGLE;
      clkout_q    <= 1'b0;
      busy_q      <= 1'b0;
      pend_div_q  <= '0;
      pend_mode_q <= MODE_TOGGLE;
    end else begin
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      mode_q      <= mode_d;
      clkout_q    <= clkout_d;
      busy_q      <= busy_d;
      pend_div_q  <= pend_div_d;
      pend_mode_q <= pend_mode_d;
    end
  end

  assign clkout = clkout_q;
  assign busy   = busy_q;

endmodule

`default_nettype wire

// File: rtl/clock_divider_n.sv
// ============================================================================
// clock_divider_n : N_CH programmable clock dividers behind a valid/ready port
// Optional macro CLKDIV_SYNC_EN adds the sync realignment input.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module clock_divider_n
  import clkdiv_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = CLKDIV_CNT_W,
  parameter int DEFAULT_DIV = 1
) (
  input  logic                   clkin,
  input  logic                   rst,
`ifdef CLKDIV_SYNC_EN
  input  logic                   sync,
`endif
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [ch_w(N_CH)-1:0]  cfg_ch,
  input  logic [CNT_W-1:0]       cfg_div,
  input  logic                   cfg_mode,
  output logic [N_CH-1:0]        clkout,
  output logic [N_CH-1:0]        busy
);

  localparam int CH_W = ch_w(N_CH);

  logic [N_CH-1:0]      busy_w;
  logic [2**CH_W-1:0]   busy_pad;
  logic                 cfg_fire;

  // Unpopulated channel indices read as idle, so writes to them are accepted and dropped
  always_comb begin
    busy_pad            = '0;
    busy_pad[N_CH-1:0]  = busy_w;
  end

  assign cfg_ready = ~busy_pad[cfg_ch];
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign busy      = busy_w;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    logic wr_en;
    assign wr_en = cfg_fire && (cfg_ch == CH_W'(i));

    clkdiv_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clkin   (clkin),
      .rst     (rst),
`ifdef CLKDIV_SYNC_EN
      .sync    (sync),
`endif
      .wr_en   (wr_en),
      .wr_div  (cfg_div),
      .wr_mode (clkdiv_mode_e'(cfg_mode)),
      .clkout  (clkout[i]),
      .busy    (busy_w[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_clock_divider_n.sv
// ============================================================================
// tb_clock_divider_n : directed + random stimulus against an epoch-based model
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_clock_divider_n;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int DD = 1;
  localparam int CW = 2;

  logic          clkin = 1'b0;
  logic          rst;
  logic          sync;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [CW-1:0] cfg_ch;
  logic [W-1:0]  cfg_div;
  logic          cfg_mode;
  logic [N-1:0]  clkout;
  logic [N-1:0]  busy;

  always #5 clkin = ~clkin;

  clock_divider_n #(
    .N_CH        (N),
    .CNT_W       (W),
    .DEFAULT_DIV (DD)
  ) dut (
    .clkin     (clkin),
    .rst       (rst),
`ifdef CLKDIV_SYNC_EN
    .sync      (sync),
`endif
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .clkout    (clkout),
    .busy      (busy)
  );

  // Model: each channel is described by the edge (epoch) at which its counter last
  // restarted at 1, its divisor/mode, and its output level at that epoch.
  int ecnt;
  int me0  [N];
  int mdiv [N];
  int mmode[N];
  bit mo0  [N];
  bit mpv  [N];
  int mpd  [N];
  int mpm  [N];
  bit acc;
  bit armed;
  int total;
  int bad;

  function automatic bit mout(int c);
    int k;
    if (mdiv[c] == 0) return 1'b0;
    k = ecnt - me0[c];
    if (k == 0) return mo0[c];
    if (mmode[c] == 0) return mo0[c] ^ (((k / mdiv[c]) % 2) == 1);
    return (k % mdiv[c]) == 0;
  endfunction

  function automatic bit model_ready();
    if (int'(cfg_ch) >= N) return 1'b1;
    return !mpv[cfg_ch];
  endfunction

  task automatic model_edge();
    bit prev[N];
    bit rdy;
    bit tc;
    rdy = model_ready();
    for (int c = 0; c < N; c++) prev[c] = mout(c);
    ecnt++;
    acc = 1'b0;
    for (int c = 0; c < N; c++) begin
      tc = (mdiv[c] != 0) && (ecnt > me0[c]) && (((ecnt - me0[c]) % mdiv[c]) == 0);
      if (rst) begin
        me0[c] = ecnt; mdiv[c] = DD; mmode[c] = 0; mo0[c] = 1'b0;
        mpv[c] = 1'b0; mpd[c] = 0; mpm[c] = 0;
      end else if (sync && (mdiv[c] != 0)) begin
        me0[c] = ecnt; mo0[c] = 1'b0;
        if (mpv[c]) begin
          mdiv[c] = mpd[c]; mmode[c] = mpm[c]; mpv[c] = 1'b0;
        end
      end else if (mpv[c] && ((mdiv[c] == 0) || tc)) begin
        if (tc && (mpd[c] != 0) && (mpm[c] == mmode[c]))
          mo0[c] = (mmode[c] == 0) ? !prev[c] : 1'b1;
        else
          mo0[c] = 1'b0;
        mdiv[c] = mpd[c]; mmode[c] = mpm[c]; me0[c] = ecnt; mpv[c] = 1'b0;
      end
    end
    if (!rst && cfg_valid && rdy) begin
      acc = 1'b1;
      if (int'(cfg_ch) < N) begin
        mpv[cfg_ch] = 1'b1; mpd[cfg_ch] = int'(cfg_div); mpm[cfg_ch] = int'(cfg_mode);
      end
    end
  endtask

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, ecnt, obs, exp);
    end
  endtask

  task automatic step();
    logic [N-1:0] eo;
    logic [N-1:0] eb;
    #1;
    if (armed) check("cfg_ready", {{(N-1){1'b0}}, cfg_ready}, {{(N-1){1'b0}}, model_ready()});
    @(posedge clkin);
    model_edge();
    @(negedge clkin);
    for (int c = 0; c < N; c++) begin
      eo[c] = mout(c);
      eb[c] = mpv[c];
    end
    check("clkout", clkout, eo);
    check("busy", busy, eb);
    armed = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic write(input int ch, input int dv, input int md);
    cfg_valid = 1'b1;
    cfg_ch    = CW'(ch);
    cfg_div   = W'(dv);
    cfg_mode  = md[0];
    for (int i = 0; i < 1000; i++) begin
      step();
      if (acc) break;
    end
    total++;
    assert (acc) else begin
      bad++;
      $error("FAIL write_timeout ch=%0d observed=stalled expected=accepted", ch);
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    ecnt = 0; total = 0; bad = 0; armed = 1'b0; acc = 1'b0;
    for (int c = 0; c < N; c++) begin
      me0[c] = 0; mdiv[c] = DD; mmode[c] = 0; mo0[c] = 1'b0;
      mpv[c] = 1'b0; mpd[c] = 0; mpm[c] = 0;
    end
    rst = 1'b1; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_mode = 1'b0;

    idle(3);
    rst = 1'b0;
    idle(6);

    write(1, 3, 0);  idle(20);
    write(2, 4, 1);  idle(20);
    write(1, 5, 0);  write(1, 2, 0);  idle(20);
    write(3, 7, 1);  idle(4);
    write(0, 0, 0);  idle(10);
    write(0, 5, 0);  idle(15);
    write(1, 4, 1);  idle(12);

`ifdef CLKDIV_SYNC_EN
    write(0, 3, 0);  idle(8);
    write(1, 6, 0);  idle(7);
    sync = 1'b1; step(); sync = 1'b0;
    idle(15);
    write(2, 2, 0);
    sync = 1'b1; step(); sync = 1'b0;
    idle(10);
`endif

    idle(5);
    rst = 1'b1; step(); rst = 1'b0;
    idle(5);

    write(2, 255, 0); idle(600);
    write(2, 255, 1); idle(520);

    repeat (300) begin
      if ($urandom_range(0, 3) == 0) begin
        write(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), int'($urandom_range(0, 1)));
      end else begin
`ifdef CLKDIV_SYNC_EN
        sync = ($urandom_range(0, 15) == 0);
`endif
        rst = ($urandom_range(0, 99) == 0);
        step();
        sync = 1'b0;
        rst  = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/clock_divider_n.md
CLOCK_DIVIDER_N -- requirements
Module: clock_divider_n

Interface
REQ-001 Parameter N_CH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 32, width of each channel's counter and divisor.
REQ-003 Parameter DEFAULT_DIV, default 1, divisor loaded into every channel at reset.
REQ-004 clkin  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 cfg_valid  input  1  configuration write request.
REQ-007 cfg_ready  output  1  configuration write accepted when high with cfg_valid.
REQ-008 cfg_ch  input  max(1,clog2(N_CH))  target channel of the write.
REQ-009 cfg_div  input  CNT_W  new divisor; 0 = channel halted.
REQ-010 cfg_mode  input  1  0 = TOGGLE (square wave), 1 = PULSE (one-cycle tick).
REQ-011 clkout  output  N_CH  per-channel divided output.
REQ-012 busy  output  N_CH  per-channel "pending configuration not yet applied".

Function
REQ-013 Each channel SHALL hold a counter running 1..div; at counter==div it SHALL return to 1 (terminal count, TC), else increment by 1.
REQ-014 TOGGLE mode: clkout SHALL invert at each TC; period = 2*div clkin cycles; div=1 gives clkin/2.
REQ-015 PULSE mode: clkout SHALL be high exactly the one cycle following each TC, low otherwise; period = div cycles; div=1 holds clkout high.
REQ-016 Handshake: write SHALL occur on the cycle cfg_valid && cfg_ready; cfg_ready = ~busy[cfg_ch], combinational.
REQ-017 Accepted write SHALL store div/mode as pending and set busy[ch] the next cycle.
REQ-018 Pending SHALL be applied at the channel's next TC (glitch-free): active div/mode <= pending, counter <= 1, busy cleared same edge.
REQ-019 A halted channel (active div=0) SHALL apply pending on the cycle after acceptance.
REQ-020 Applying div=0 SHALL force clkout low and hold counter at 1 until a nonzero divisor is applied.
REQ-021 Applying a mode change SHALL force clkout to 0 at application, then follow REQ-014/015.
REQ-022 cfg_ch >= N_CH SHALL be accepted (cfg_ready high) and discarded with no state change.
REQ-023 Counter arithmetic SHALL be unsigned CNT_W; div = 2^CNT_W-1 SHALL work without overflow.

Reset
REQ-024 On rst: counters = 1, active div = DEFAULT_DIV, mode = TOGGLE, clkout = 0, busy = 0, pending cleared.
REQ-025 rst SHALL override any in-flight write or pending configuration, which is discarded.

Configuration
REQ-026 Macro CLKDIV_SYNC_EN SHALL compile in input sync (1 bit): when high, every channel with nonzero active div SHALL set counter = 1, clkout = 0 and apply any pending configuration immediately.
REQ-027 sync SHALL take priority over TC in the same cycle; rst SHALL take priority over sync.
REQ-028 Without CLKDIV_SYNC_EN, port sync SHALL not exist and channels realign only through TC.

Structure
REQ-029 Package clkdiv_pkg SHALL hold the mode encoding (TOGGLE=0, PULSE=1) and the default CNT_W.
REQ-030 Per-channel counter, active/pending registers and output logic SHALL be one sub-module clkdiv_chan, instantiated N_CH times; top holds the cfg decode only.

Verification
REQ-031 Reset, DEFAULT_DIV=1 -> every clkout toggles every cycle (clkin/2), busy=0.
REQ-032 Write ch1 div=3 TOGGLE -> busy[1] high until TC, then clkout[1] high 3 / low 3 cycles.
REQ-033 Write ch2 div=4 PULSE -> clkout[2] one-cycle high every 4 cycles; no runt pulse at switchover.
REQ-034 Second write to ch1 while busy[1] -> cfg_ready low, write stalls until TC, then accepted.
REQ-035 Write ch0 div=0, then div=5 -> clkout[0] low and static, restarts one cycle after second accept.
REQ-036 With CLKDIV_SYNC_EN, ch0 div=3 and ch1 div=6 mid-period, pulse sync -> both restart from counter 1 with clkout=0 aligned; rst asserted mid-run -> REQ-024 state next cycle.
